// File: rtl/axi_ic_pkg.sv
// Shared interconnect definitions: arbiter state encoding and master indices.
package axi_ic_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin pick: on a tie the requester that was not served last wins.
module rr_pick2
  import axi_ic_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  // Pure decode of the request vector against the last-served index.
  always_comb begin
    gnt_valid_o = |req_i;
    unique case (req_i)
      2'b11:   gnt_idx_o = ~last_i;
      2'b10:   gnt_idx_o = M1;
      default: gnt_idx_o = M0;
    endcase
  end

endmodule

// File: rtl/axi_ar_rr_arbiter.sv
// Two-master to one-slave AR/R arbiter. Grant is held from the AR handshake
// through the RLAST beat; `sel` drives the external AR payload mux.
// Optional stall abort in the R phase is enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_ar_rr_arbiter
  import axi_ic_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic M0_ARVALID,
  input  logic M1_ARVALID,
  output logic M0_ARREADY,
  output logic M1_ARREADY,
  output logic S_ARVALID,
  input  logic S_ARREADY,
  input  logic S_RVALID,
  input  logic S_RLAST,
  output logic S_RREADY,
  output logic M0_RVALID,
  output logic M1_RVALID,
  input  logic M0_RREADY,
  input  logic M1_RREADY,
  output logic sel,
  output logic busy,
  output logic timeout_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;
  logic       gnt_valid, gnt_idx;
  logic       m_arvalid, m_rready;
  logic       ar_hs, r_hs;
  logic       timeout_hit;

  rr_pick2 u_pick (
    .req_i       ({M1_ARVALID, M0_ARVALID}),
    .last_i      (last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Signals of the currently granted master.
  assign m_arvalid = sel_q ? M1_ARVALID : M0_ARVALID;
  assign m_rready  = sel_q ? M1_RREADY : M0_RREADY;

  assign ar_hs = (state_q == StAddr) && m_arvalid && S_ARREADY;
  assign r_hs  = (state_q == StData) && S_RVALID && m_rready;

  // Route handshakes to/from the granted master only; everything idle outside its phase.
  always_comb begin
    S_ARVALID  = 1'b0;
    M0_ARREADY = 1'b0;
    M1_ARREADY = 1'b0;
    S_RREADY   = 1'b0;
    M0_RVALID  = 1'b0;
    M1_RVALID  = 1'b0;
    if (state_q == StAddr) begin
      S_ARVALID  = m_arvalid;
      M0_ARREADY = (sel_q == M0) && S_ARREADY;
      M1_ARREADY = (sel_q == M1) && S_ARREADY;
    end else if (state_q == StData) begin
      S_RREADY  = m_rready;
      M0_RVALID = (sel_q == M0) && S_RVALID;
      M1_RVALID = (sel_q == M1) && S_RVALID;
    end
  end

  assign sel  = sel_q;
  assign busy = (state_q != StIdle);

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stall counter: zero outside DATA, cleared by every R handshake.
  always_comb begin
    timeout_hit = (state_q == StData) && !r_hs && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d       = '0;
    if ((state_q == StData) && !r_hs && !timeout_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_err = timeout_hit;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state: grant in IDLE, wait for AR handshake, release on last beat or abort.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          sel_d   = gnt_idx;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (ar_hs) begin
          state_d = StData;
        end
      end
      StData: begin
        if ((r_hs && S_RLAST) || timeout_hit) begin
          last_d  = sel_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; after reset M0 wins the first tie.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= StIdle;
      sel_q   <= M0;
      last_q  <= M1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_axi_ar_rr_arbiter.sv
// Self-checking bench for axi_ar_rr_arbiter: directed scenarios followed by random
// traffic, each cycle compared against a transaction-level ownership model.
module tb_axi_ar_rr_arbiter;

  localparam int unsigned TO = 8;

  logic ACLK = 1'b0;
  logic ARESETN;
  logic M0_ARVALID, M1_ARVALID, M0_ARREADY, M1_ARREADY;
  logic S_ARVALID, S_ARREADY, S_RVALID, S_RLAST, S_RREADY;
  logic M0_RVALID, M1_RVALID, M0_RREADY, M1_RREADY;
  logic sel, busy, timeout_err;

  always #5 ACLK = ~ACLK;

  axi_ar_rr_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .M0_ARVALID  (M0_ARVALID),
    .M1_ARVALID  (M1_ARVALID),
    .M0_ARREADY  (M0_ARREADY),
    .M1_ARREADY  (M1_ARREADY),
    .S_ARVALID   (S_ARVALID),
    .S_ARREADY   (S_ARREADY),
    .S_RVALID    (S_RVALID),
    .S_RLAST     (S_RLAST),
    .S_RREADY    (S_RREADY),
    .M0_RVALID   (M0_RVALID),
    .M1_RVALID   (M1_RVALID),
    .M0_RREADY   (M0_RREADY),
    .M1_RREADY   (M1_RREADY),
    .sel         (sel),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int total = 0;
  int bad   = 0;

  // Ownership model: who holds the slave, whether its address was accepted.
  int owner;
  bit addr_done;
  bit last_m;
  bit exp_sel;
  int stall;

  // Traffic generator state.
  int want[2];
  int beat, cur_len, blen;
  int p_arready, p_rvalid, p_rready;

  bit   busy_prev = 1'b0;
  logic grants[$];
  int   wrong_ardy = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] dut_outs();
    return {S_ARVALID, M0_ARREADY, M1_ARREADY, S_RREADY, M0_RVALID, M1_RVALID, sel, busy,
            timeout_err};
  endfunction

  function automatic logic [8:0] model_outs();
    logic [8:0] o;
    logic [1:0] arv;
    logic [1:0] rr;
    o    = '0;
    arv  = {M1_ARVALID, M0_ARVALID};
    rr   = {M1_RREADY, M0_RREADY};
    o[2] = exp_sel;
    if (owner >= 0) begin
      o[1] = 1'b1;
      if (!addr_done) begin
        o[8] = arv[owner[0]];
        if (owner == 0) o[7] = S_ARREADY;
        else o[6] = S_ARREADY;
      end else begin
        o[5] = rr[owner[0]];
        if (owner == 0) o[4] = S_RVALID;
        else o[3] = S_RVALID;
`ifdef AXI_ARB_TIMEOUT_EN
        o[0] = !(S_RVALID && rr[owner[0]]) && (stall == TO - 1);
`endif
      end
    end
    return o;
  endfunction

  task automatic model_reset();
    owner = -1; addr_done = 0; last_m = 1; exp_sel = 0; stall = 0; beat = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [1:0] req;
    logic [1:0] rr;
    bit rhs;
    req = {M1_ARVALID, M0_ARVALID};
    rr  = {M1_RREADY, M0_RREADY};
    if (ARESETN !== 1'b1) begin
      model_reset();
      return;
    end
    if (owner < 0) begin
      if (req != 2'b00) begin
        owner     = (req == 2'b11) ? int'(!last_m) : int'(req[1]);
        exp_sel   = owner[0];
        addr_done = 0;
      end
    end else if (!addr_done) begin
      if (req[owner[0]] && S_ARREADY) begin
        addr_done = 1;
        stall     = 0;
        beat      = 0;
        if (want[owner] > 0) want[owner]--;
        cur_len = (blen > 0) ? blen : int'($urandom_range(4, 1));
      end
    end else begin
      rhs = S_RVALID && rr[owner[0]];
      if (rhs) begin
        beat++;
        stall = 0;
        if (S_RLAST) begin
          last_m = owner[0];
          owner  = -1;
        end
      end else begin
        stall++;
`ifdef AXI_ARB_TIMEOUT_EN
        if (stall == TO) begin
          last_m = owner[0];
          owner  = -1;
          stall  = 0;
        end
`endif
      end
    end
  endtask

  task automatic step(input string tag);
    #1;
    chk({tag, ":outs"}, dut_outs(), model_outs());
    if (busy === 1'b1 && !busy_prev) grants.push_back(sel);
    busy_prev = (busy === 1'b1);
    if ((owner != 0 && M0_ARREADY === 1'b1) || (owner != 1 && M1_ARREADY === 1'b1)) wrong_ardy++;
    model_edge();
    @(negedge ACLK);
  endtask

  task automatic drive();
    M0_ARVALID = (want[0] > 0);
    M1_ARVALID = (want[1] > 0);
    S_ARREADY  = ($urandom_range(99) < p_arready);
    M0_RREADY  = ($urandom_range(99) < p_rready);
    M1_RREADY  = ($urandom_range(99) < p_rready);
    if (owner >= 0 && addr_done) begin
      S_RVALID = ($urandom_range(99) < p_rvalid);
      S_RLAST  = (beat == cur_len - 1);
    end else begin
      // Garbage on R outside the data phase must be ignored.
      S_RVALID = 1'($urandom_range(1));
      S_RLAST  = 1'($urandom_range(1));
    end
  endtask

  task automatic drain(input int max, input string tag);
    int k;
    k = 0;
    while ((want[0] > 0 || want[1] > 0 || owner >= 0) && k < max) begin
      drive();
      step(tag);
      k++;
    end
    #1;
    chk({tag, ":idle_after_drain"}, busy, 1'b0);
  endtask

  task automatic clear_inputs();
    M0_ARVALID = 0; M1_ARVALID = 0; S_ARREADY = 0; S_RVALID = 0; S_RLAST = 0;
    M0_RREADY = 0; M1_RREADY = 0;
  endtask

  task automatic do_reset();
    want = '{0, 0};
    clear_inputs();
    ARESETN = 0;
    step("rst");
    step("rst");
    ARESETN = 1;
  endtask

  initial begin
    int k;
    logic [31:0] exp_g;
    clear_inputs();
    want = '{0, 0};
    blen = 1; p_arready = 100; p_rvalid = 100; p_rready = 100;
    ARESETN = 0;
    repeat (2) @(negedge ACLK);
    model_reset();
    #1;
    chk("reset_outs", dut_outs(), 9'd0);
    step("rst");

    // T1: lone M0 request, single-beat read.
    ARESETN = 1; M0_ARVALID = 1; S_ARREADY = 1;
    #1; chk("t1_idle_no_arvalid", S_ARVALID, 1'b0);
    step("t1");
    #1; chk("t1_arvalid", S_ARVALID, 1'b1); chk("t1_sel", sel, 1'b0);
    step("t1");
    M0_ARVALID = 0; S_RVALID = 1; S_RLAST = 1; M0_RREADY = 1;
    #1; chk("t1_rvalid", M0_RVALID, 1'b1); chk("t1_busy", busy, 1'b1);
    step("t1");
    S_RVALID = 0; S_RLAST = 0;
    #1; chk("t1_busy_fall", busy, 1'b0);
    step("t1");

    // T2: both masters hold requests, 4-beat bursts, slave always ready.
    do_reset();
    grants.delete(); wrong_ardy = 0; blen = 4; want = '{2, 2};
    drain(200, "t2");
    chk("t2_ngrants", grants.size(), 4);
    for (int i = 0; i < 4; i++) begin
      exp_g = i % 2;
      if (i < grants.size()) chk($sformatf("t2_grant%0d", i), grants[i], exp_g);
    end
    chk("t2_ardy_nongranted", wrong_ardy, 0);

    // T3: M1 burst with its RREADY low for 3 cycles mid-burst.
    want = '{0, 1}; k = 0;
    while (!(owner == 1 && addr_done && beat == 2) && k < 50) begin drive(); step("t3"); k++; end
    #1; chk("t3_granted_m1", {busy, sel}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      drive(); M1_RREADY = 0; S_RVALID = 1; S_RLAST = 0;
      #1; chk($sformatf("t3_srready_low%0d", i), {S_RREADY, M0_RVALID, M1_RVALID}, 3'b001);
      step("t3");
    end
    drain(50, "t3");

    // T4: reset asserted during beat 2 of a 4-beat M1 burst.
    want = '{0, 1}; k = 0;
    while (!(owner == 1 && addr_done && beat == 1) && k < 50) begin drive(); step("t4"); k++; end
    drive(); ARESETN = 0;
    #1; chk("t4_pre_sel", sel, 1'b1);
    step("t4");
    want = '{0, 0}; ARESETN = 1;
    M0_ARVALID = 0; M1_ARVALID = 0; S_RVALID = 1; M0_RREADY = 1; M1_RREADY = 1;
    #1; chk("t4_outs_after_reset", dut_outs(), 9'd0);
    step("t4");
    want = '{1, 1}; blen = 1;
    drive(); step("t4");
    #1; chk("t4_tie_m0", {busy, sel}, 2'b10);
    drain(100, "t4");

    // T5: slave withholds ARREADY; grant (M0, since M1 was served last) must hold.
    p_arready = 0; want = '{1, 1};
    drive(); step("t5");
    for (int i = 0; i < 10; i++) begin
      drive();
      #1; chk($sformatf("t5_hold%0d", i), {busy, sel, S_ARVALID, M0_ARREADY, M1_ARREADY}, 5'b10100);
      step("t5");
    end
    p_arready = 100;
    drain(100, "t5");

    // T6: R channel stalls forever in DATA.
    p_rvalid = 0; want = '{1, 0}; k = 0;
    while (!(owner == 0 && addr_done) && k < 20) begin drive(); step("t6"); k++; end
`ifdef AXI_ARB_TIMEOUT_EN
    for (int i = 0; i < int'(TO); i++) begin
      drive();
      #1; chk($sformatf("t6_terr%0d", i), timeout_err, (i == int'(TO) - 1));
      step("t6");
    end
    #1; chk("t6_idle_after_abort", busy, 1'b0);
`else
    for (int i = 0; i < 100; i++) begin drive(); step("t6"); end
    #1; chk("t6_still_data", {busy, timeout_err, S_ARVALID}, 3'b100);
`endif
    p_rvalid = 100;
    drain(50, "t6");

    // Random traffic.
    for (int t = 0; t < 30; t++) begin
      want[0] = int'($urandom_range(3));
      want[1] = int'($urandom_range(3));
      blen = 0;
      p_arready = int'($urandom_range(100, 50));
      p_rvalid  = int'($urandom_range(100, 50));
      p_rready  = int'($urandom_range(100, 50));
      drain(1000, $sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_ar_rr_arbiter.md
Name: axi_ar_rr_arbiter

Overview:
- Two-master to one-slave read-channel arbiter for the interconnect.
- Grants the shared slave AR/R path to M0 or M1 using round-robin.
- Drives `sel` of the AR-payload 2:1 mux (sel=0 → M0, sel=1 → M1).
- Routes the AR/R handshake signals and holds the grant from address handshake through the RLAST beat.

Parameters:
- TIMEOUT_CYCLES, 256, R-phase stall limit in cycles (used only with the optional feature; must be ≥2).
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived; do not override).

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  reset; synchronous, active-low.
- M0_ARVALID  in  1  master 0 read-address request.
- M1_ARVALID  in  1  master 1 read-address request.
- M0_ARREADY  out  1  AR accept to master 0.
- M1_ARREADY  out  1  AR accept to master 1.
- S_ARVALID  out  1  AR valid to slave.
- S_ARREADY  in  1  AR ready from slave.
- S_RVALID  in  1  R valid from slave.
- S_RLAST  in  1  R last beat from slave.
- S_RREADY  out  1  R ready to slave.
- M0_RVALID  out  1  R valid to master 0.
- M1_RVALID  out  1  R valid to master 1.
- M0_RREADY  in  1  R ready from master 0.
- M1_RREADY  in  1  R ready from master 1.
- sel  out  1  mux select; 0 = M0, 1 = M1.
- busy  out  1  high whenever the state is not IDLE.
- timeout_err  out  1  one-cycle stall-abort pulse (optional feature only; otherwise tied 0).

Behaviour:
- Registers:
  - state ∈ {IDLE, ADDR, DATA}.
  - sel_q.
  - last_q: last master served.
- Reset (ARESETN=0 at a clock edge):
  - state=IDLE, sel_q=0, last_q=1.
  - All outputs 0.
  - Reset mid-burst aborts the transfer immediately; no R beat is forwarded after it.
- IDLE:
  - All handshake outputs are 0; sel holds its last value.
  - Only M0 requests → grant M0; only M1 requests → grant M1.
  - Both request → grant the master ≠ last_q. After reset, M0 wins the first tie.
  - On a grant: sel_q ← granted index, state → ADDR at the next edge. Arbitration latency is 1 cycle.
- ADDR:
  - S_ARVALID = granted Mx_ARVALID.
  - Granted Mx_ARREADY = S_ARREADY; the other Mx_ARREADY = 0.
  - On S_ARVALID & S_ARREADY: state → DATA.
  - The grant is never revoked in ADDR, even if the master drops ARVALID (protocol violation; the arbiter waits).
- DATA:
  - S_ARVALID = 0; both Mx_ARREADY = 0.
  - Granted Mx_RVALID = S_RVALID; the other Mx_RVALID = 0.
  - S_RREADY = granted Mx_RREADY.
  - On S_RVALID & S_RREADY & S_RLAST: last_q ← sel_q, state → IDLE.
  - The next grant is issued in the IDLE cycle that follows, so there is one dead cycle between transactions.
- The non-granted master's request is held pending with no timeout of its own; fairness comes from round-robin.
- All outputs are combinational decodes of state/sel_q plus the routed inputs; there is no combinational path from ARVALID to sel.
- S_RVALID arriving outside DATA is ignored (S_RREADY=0).

Optional Feature:
- Macro: AXI_ARB_TIMEOUT_EN.
- Defined:
  - A CNT_W counter clears on entry to DATA and on every R handshake.
  - It increments each DATA cycle without a handshake.
  - When it reaches TIMEOUT_CYCLES: state → IDLE, last_q ← sel_q, timeout_err=1 for exactly one cycle, counter clears.
  - Reset clears the counter and timeout_err.
- Undefined: no counter is instantiated and timeout_err is constant 0.

Decomposition:
- Shared package axi_ic_pkg: state encoding constants (IDLE=2'd0, ADDR=2'd1, DATA=2'd2) and master index constants M0=1'b0, M1=1'b1.
- Sub-module rr_pick2 (combinational): inputs req[1:0] and last; outputs gnt_valid and gnt_idx.
- This block instantiates alongside the existing 2:1 mux, which it drives through `sel`.

Test Plan:
- Reset release, M0_ARVALID=1 only, S_ARREADY=1 → sel=0, S_ARVALID=1 one cycle after the request; single beat with RLAST=1 → busy falls the cycle after the beat.
- Both ARVALID held high, 4-beat bursts, slave always ready → grant order M0, M1, M0, M1; ARREADY never to the non-granted master.
- Granted M1 with M1_RREADY=0 for 3 cycles mid-burst → S_RREADY=0 for those cycles; M0_RVALID stays 0 throughout.
- ARESETN=0 during beat 2 of 4 → next cycle: state IDLE, all outputs 0, sel=0; a subsequent tie grants M0.
- S_ARREADY held 0 for 10 cycles while granted → stays in ADDR with sel stable; the other master is not served.
- AXI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, S_RVALID stuck 0 in DATA → timeout_err pulses on the 8th stalled cycle, then the state is IDLE; without the macro, still in DATA after 100 cycles with timeout_err=0.
